// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and encodings for the memory bus arbiter: FSM states,
// transaction owner and the bus size codes.
package mem_bus_arbiter_pkg;

    // Arbiter FSM: one transaction in flight, address phase then data phase.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    // Which side owns the transaction currently on the bus.
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } arb_owner_t;

    // Bus size codes.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, its two clients (fetch and LSU) and the
// shared sram-like memory bus. The master modport is the arbiter's view: it
// masters the shared bus and answers both clients. The slave modport is the
// environment's view (clients plus memory).
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch side
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_addr_ok;
    logic                  inst_data_ok;
    logic [DATA_W-1:0]     inst_rdata;
    // data side
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [DATA_W-1:0]     data_rdata;
    // pipeline flush
    logic                  ex_en;
    // shared memory bus
    logic                  bus_req;
    logic                  bus_wr;
    logic [1:0]            bus_size;
    logic [DATA_W/8-1:0]   bus_wstrb;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;
    // status
    logic                  busy;

    modport master (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        input  ex_en,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output busy
    );

    modport slave (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        output ex_en,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one sram-like bus between instruction fetch
// (read only) and the LSU (read/write). One transaction in flight; the data
// side wins ties, but after STARVE_LIMIT consecutive data grants with fetch
// waiting, fetch is forced through. A flush during an owned fetch lets the
// bus transaction finish but swallows its response.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    mem_bus_arbiter_if.master  arb
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // Request fields as presented on the bus.
    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_fld_t;

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              discard_q, discard_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    bus_fld_t          fld_p0;
    bus_fld_t          fld_p1;

    logic              inst_starved;
    logic              grant_data;
    logic              grant_inst;
    logic              resp;
    logic              inst_ok;
    logic              data_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
    endfunction

    // Grant decision in IDLE: data first unless fetch has waited out its limit.
    // Grants are masked during reset so every output reads 0 while rstn is low.
    always_comb begin
        inst_starved = arb.inst_req && (starve_q == CNT_MAX);
        grant_data   = rstn && (state_q == ARB_IDLE) && arb.data_req && !inst_starved;
        grant_inst   = rstn && (state_q == ARB_IDLE) && arb.inst_req && !arb.ex_en
                       && !grant_data;
    end

    // Select the request fields to latch when a grant is given.
    always_comb begin
        fld_p0 = fld_p1;
        if (grant_data) begin
            fld_p0 = '{wr:    arb.data_wr,
                       size:  arb.data_size,
                       wstrb: arb.data_wstrb,
                       addr:  arb.data_addr,
                       wdata: arb.data_wdata};
        end else if (grant_inst) begin
            fld_p0 = '{wr:    1'b0,
                       size:  SIZE_WORD,
                       wstrb: '0,
                       addr:  arb.inst_addr,
                       wdata: '0};
        end
    end

    // Next-state logic: FSM, owner, flush-discard flag and starvation counter.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        discard_d = discard_q;
        starve_d  = starve_q;
        case (state_q)
            ARB_IDLE: begin
                discard_d = 1'b0;
                if (grant_data) begin
                    state_d  = ARB_ADDR;
                    owner_d  = OWN_DATA;
                    starve_d = arb.inst_req ? sat_inc(starve_q) : '0;
                end else if (grant_inst) begin
                    state_d  = ARB_ADDR;
                    owner_d  = OWN_INST;
                    starve_d = '0;
                end else if (!arb.inst_req) begin
                    starve_d = '0;
                end
            end
            ARB_ADDR: begin
                if (owner_q == OWN_INST && arb.ex_en) begin
                    discard_d = 1'b1;
                end
                // A response in the same cycle as acceptance is not honoured.
                if (arb.bus_addr_ok) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (arb.bus_data_ok) begin
                    state_d   = ARB_IDLE;
                    discard_d = 1'b0;
                end else if (owner_q == OWN_INST && arb.ex_en) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Client responses and bus drive. A flush arriving in the very cycle of
    // the fetch response also suppresses it, so no stale instruction escapes.
    always_comb begin
        resp    = (state_q == ARB_DATA) && arb.bus_data_ok;
        inst_ok = resp && (owner_q == OWN_INST) && !discard_q && !arb.ex_en;
        data_ok = resp && (owner_q == OWN_DATA);

        arb.inst_addr_ok = grant_inst;
        arb.data_addr_ok = grant_data;
        arb.inst_data_ok = inst_ok;
        arb.inst_rdata   = inst_ok ? arb.bus_rdata : '0;
        arb.data_data_ok = data_ok;
        arb.data_rdata   = (data_ok && !fld_p1.wr) ? arb.bus_rdata : '0;

        arb.bus_req   = (state_q == ARB_ADDR);
        arb.bus_wr    = fld_p1.wr;
        arb.bus_size  = fld_p1.size;
        arb.bus_wstrb = fld_p1.wstrb;
        arb.bus_addr  = fld_p1.addr;
        arb.bus_wdata = fld_p1.wdata;
        arb.busy      = (state_q != ARB_IDLE);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_INST;
            discard_q <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
            starve_q  <= starve_d;
        end
    end

    // ---- stage p0 -> p1: latched request fields driven onto the bus ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fld_p1 <= '0;
        end else begin
            fld_p1 <= fld_p0;
        end
    end

    // The bus must never accept a request and respond to it in one cycle.
    a_no_addr_and_data_ok: assert property (
        @(posedge clk) disable iff (!rstn)
        (state_q == ARB_ADDR) |-> !(arb.bus_addr_ok && arb.bus_data_ok)
    );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a grant-decision vector table, hand-written
// multi-cycle sequences, then randomized traffic against a transaction-level
// reference model.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic clk;
    logic rstn;

    int n_vec;
    int n_err;

    mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .arb  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic inst_req;
        logic data_req;
        logic ex_en;
        logic exp_inst_ok;
        logic exp_data_ok;
    } grant_vec_t;

    grant_vec_t gtab[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifc.inst_req    = 1'b0;
        ifc.inst_addr   = '0;
        ifc.data_req    = 1'b0;
        ifc.data_wr     = 1'b0;
        ifc.data_size   = 2'd0;
        ifc.data_wstrb  = '0;
        ifc.data_addr   = '0;
        ifc.data_wdata  = '0;
        ifc.ex_en       = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b0;
        ifc.bus_rdata   = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Called one cycle after a grant. Holds bus_addr_ok low for a_wait cycles,
    // accepts, waits d_wait cycles, then returns with bus_data_ok asserted and
    // settled so the caller can check the response.
    task automatic serve(input int a_wait, input int d_wait, input logic [31:0] rd);
        for (int i = 0; i < a_wait; i++) begin
            #1 chk("bus_req_held", 64'(ifc.bus_req), 64'(1));
            next_cycle();
        end
        ifc.bus_addr_ok = 1'b1;
        #1 chk("bus_req_accept", 64'(ifc.bus_req), 64'(1));
        next_cycle();
        ifc.bus_addr_ok = 1'b0;
        for (int i = 0; i < d_wait; i++) begin
            #1 chk("bus_req_dropped", 64'(ifc.bus_req), 64'(0));
            next_cycle();
        end
        ifc.bus_data_ok = 1'b1;
        ifc.bus_rdata   = rd;
        #1;
    endtask

    task automatic end_resp();
        next_cycle();
        ifc.bus_data_ok = 1'b0;
        ifc.bus_rdata   = '0;
    endtask

    function automatic logic pct(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // reference model state (transaction level)
    logic              m_active;
    logic              m_acc;
    logic              m_inst;
    logic              m_drop;
    int                m_starve;
    logic              m_wr;
    logic [1:0]        m_size;
    logic [3:0]        m_wstrb;
    logic [31:0]       m_addr;
    logic [31:0]       m_wdata;

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        clear_inputs();

        // inst, data, ex_en -> inst_addr_ok, data_addr_ok
        gtab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        gtab[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        gtab[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        gtab[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        gtab[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        gtab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        gtab[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gtab[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        // ---------------- grant table ----------------
        for (int v = 0; v < 8; v++) begin
            do_reset();
            chk("reset_busy", 64'(ifc.busy), 64'(0));
            chk("reset_bus_req", 64'(ifc.bus_req), 64'(0));
            ifc.inst_req  = gtab[v].inst_req;
            ifc.inst_addr = 32'h1C00_0100;
            ifc.data_req  = gtab[v].data_req;
            ifc.data_addr = 32'h0000_0200;
            ifc.ex_en     = gtab[v].ex_en;
            #1;
            chk("tab_inst_addr_ok", 64'(ifc.inst_addr_ok), 64'(gtab[v].exp_inst_ok));
            chk("tab_data_addr_ok", 64'(ifc.data_addr_ok), 64'(gtab[v].exp_data_ok));
            next_cycle();
            clear_inputs();
            #1;
            chk("tab_busy", 64'(ifc.busy), 64'(gtab[v].exp_inst_ok | gtab[v].exp_data_ok));
            chk("tab_bus_addr", 64'(ifc.bus_addr),
                gtab[v].exp_data_ok ? 64'h200 : (gtab[v].exp_inst_ok ? 64'h1C00_0100 : 64'h0));
        end

        // ---------------- reset mid-DATA ----------------
        do_reset();
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'h1C00_0008;
        next_cycle();
        ifc.inst_req    = 1'b0;
        ifc.bus_addr_ok = 1'b1;
        next_cycle();
        ifc.bus_addr_ok = 1'b0;
        #1 chk("rst_pre_busy", 64'(ifc.busy), 64'(1));
        rstn            = 1'b0;
        ifc.inst_req    = 1'b1;
        ifc.bus_data_ok = 1'b1;
        ifc.bus_rdata   = 32'h1111_2222;
        #1;
        chk("rst_busy", 64'(ifc.busy), 64'(0));
        chk("rst_bus_req", 64'(ifc.bus_req), 64'(0));
        chk("rst_inst_data_ok", 64'(ifc.inst_data_ok), 64'(0));
        chk("rst_inst_rdata", 64'(ifc.inst_rdata), 64'(0));
        chk("rst_inst_addr_ok", 64'(ifc.inst_addr_ok), 64'(0));
        chk("rst_bus_addr", 64'(ifc.bus_addr), 64'(0));
        next_cycle();
        clear_inputs();
        rstn = 1'b1;
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'h1C00_0000;
        #1 chk("rst_after_inst_addr_ok", 64'(ifc.inst_addr_ok), 64'(1));
        next_cycle();
        ifc.inst_req = 1'b0;
        #1 chk("rst_after_bus_addr", 64'(ifc.bus_addr), 64'h1C00_0000);
        serve(0, 0, 32'h0340_0000);
        chk("rst_after_inst_data_ok", 64'(ifc.inst_data_ok), 64'(1));
        chk("rst_after_inst_rdata", 64'(ifc.inst_rdata), 64'h0340_0000);
        end_resp();

        // ---------------- inst read with bus latency ----------------
        do_reset();
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'h1C00_0004;
        #1 chk("rd_inst_addr_ok", 64'(ifc.inst_addr_ok), 64'(1));
        next_cycle();
        ifc.inst_req = 1'b0;
        #1;
        chk("rd_bus_addr", 64'(ifc.bus_addr), 64'h1C00_0004);
        chk("rd_bus_wr", 64'(ifc.bus_wr), 64'(0));
        chk("rd_bus_size", 64'(ifc.bus_size), 64'(2));
        chk("rd_bus_wstrb", 64'(ifc.bus_wstrb), 64'(0));
        serve(1, 1, 32'h0280_0C0C);
        chk("rd_inst_data_ok", 64'(ifc.inst_data_ok), 64'(1));
        chk("rd_inst_rdata", 64'(ifc.inst_rdata), 64'h0280_0C0C);
        chk("rd_data_data_ok", 64'(ifc.data_data_ok), 64'(0));
        end_resp();
        #1;
        chk("rd_inst_data_ok_pulse", 64'(ifc.inst_data_ok), 64'(0));
        chk("rd_inst_rdata_zero", 64'(ifc.inst_rdata), 64'(0));
        chk("rd_idle", 64'(ifc.busy), 64'(0));

        // ---------------- contention ----------------
        do_reset();
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'h1C00_0010;
        ifc.data_req  = 1'b1;
        ifc.data_addr = 32'h0000_1000;
        ifc.data_size = 2'd2;
        #1;
        chk("ct_data_addr_ok", 64'(ifc.data_addr_ok), 64'(1));
        chk("ct_inst_addr_ok", 64'(ifc.inst_addr_ok), 64'(0));
        next_cycle();
        ifc.data_req = 1'b0;
        #1 chk("ct_inst_wait", 64'(ifc.inst_addr_ok), 64'(0));
        serve(0, 0, 32'hCAFE_0001);
        chk("ct_data_data_ok", 64'(ifc.data_data_ok), 64'(1));
        chk("ct_data_rdata", 64'(ifc.data_rdata), 64'hCAFE_0001);
        chk("ct_inst_data_ok", 64'(ifc.inst_data_ok), 64'(0));
        end_resp();
        #1 chk("ct_inst_next", 64'(ifc.inst_addr_ok), 64'(1));
        next_cycle();
        ifc.inst_req = 1'b0;
        #1 chk("ct_inst_bus_addr", 64'(ifc.bus_addr), 64'h1C00_0010);
        serve(0, 0, 32'h0000_0013);
        chk("ct_inst_served", 64'(ifc.inst_data_ok), 64'(1));
        end_resp();

        // ---------------- starvation ----------------
        do_reset();
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'h1C00_0020;
        ifc.data_req  = 1'b1;
        ifc.data_addr = 32'h0000_3000;
        for (int g = 0; g < 10; g++) begin
            #1;
            chk("sv_data_grant", 64'(ifc.data_addr_ok), 64'((g % 5) != 4));
            chk("sv_inst_grant", 64'(ifc.inst_addr_ok), 64'((g % 5) == 4));
            next_cycle();
            serve(0, 0, 32'h0);
            end_resp();
        end

        // ---------------- flush during owned fetch ----------------
        do_reset();
        ifc.inst_req  = 1'b1;
        ifc.inst_addr = 32'h1C00_0040;
        #1 chk("fl_inst_addr_ok", 64'(ifc.inst_addr_ok), 64'(1));
        next_cycle();
        ifc.inst_req = 1'b0;
        ifc.ex_en    = 1'b1;
        next_cycle();
        ifc.ex_en = 1'b0;
        serve(0, 0, 32'hBAD0_BAD0);
        chk("fl_inst_data_ok", 64'(ifc.inst_data_ok), 64'(0));
        chk("fl_inst_rdata", 64'(ifc.inst_rdata), 64'(0));
        chk("fl_busy", 64'(ifc.busy), 64'(1));
        end_resp();
        #1 chk("fl_idle", 64'(ifc.busy), 64'(0));

        // ---------------- byte write ----------------
        do_reset();
        ifc.data_req   = 1'b1;
        ifc.data_wr    = 1'b1;
        ifc.data_size  = 2'd0;
        ifc.data_wstrb = 4'b0100;
        ifc.data_addr  = 32'h0000_2002;
        ifc.data_wdata = 32'h00AB_0000;
        #1 chk("wr_data_addr_ok", 64'(ifc.data_addr_ok), 64'(1));
        next_cycle();
        ifc.data_req   = 1'b0;
        ifc.data_wr    = 1'b0;
        ifc.data_size  = 2'd2;
        ifc.data_wstrb = 4'hF;
        ifc.data_addr  = 32'hFFFF_FFFF;
        ifc.data_wdata = 32'h1234_5678;
        #1;
        chk("wr_bus_req", 64'(ifc.bus_req), 64'(1));
        chk("wr_bus_wr", 64'(ifc.bus_wr), 64'(1));
        chk("wr_bus_size", 64'(ifc.bus_size), 64'(0));
        chk("wr_bus_wstrb", 64'(ifc.bus_wstrb), 64'h4);
        chk("wr_bus_addr", 64'(ifc.bus_addr), 64'h0000_2002);
        chk("wr_bus_wdata", 64'(ifc.bus_wdata), 64'h00AB_0000);
        serve(0, 0, 32'hDEAD_BEEF);
        chk("wr_data_data_ok", 64'(ifc.data_data_ok), 64'(1));
        chk("wr_data_rdata", 64'(ifc.data_rdata), 64'(0));
        end_resp();

        // ---------------- randomized against reference model ----------------
        do_reset();
        m_active = 1'b0; m_acc = 1'b0; m_inst = 1'b0; m_drop = 1'b0; m_starve = 0;
        m_wr = 1'b0; m_size = 2'd0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic gd, gi, rsp, e_iok, e_dok;
            ifc.inst_req    = pct(60);
            ifc.inst_addr   = $urandom;
            ifc.data_req    = pct(50);
            ifc.data_wr     = pct(50);
            ifc.data_size   = 2'($urandom_range(0, 3));
            ifc.data_wstrb  = 4'($urandom_range(0, 15));
            ifc.data_addr   = $urandom;
            ifc.data_wdata  = $urandom;
            ifc.ex_en       = pct(10);
            ifc.bus_addr_ok = pct(50);
            ifc.bus_data_ok = (m_active && !m_acc) ? 1'b0 : pct(40);
            ifc.bus_rdata   = $urandom;
            #1;
            gd = !m_active && ifc.data_req && !(ifc.inst_req && m_starve >= LIMIT);
            gi = !m_active && !gd && ifc.inst_req && !ifc.ex_en;
            rsp   = m_active && m_acc && ifc.bus_data_ok;
            e_iok = rsp && m_inst && !m_drop && !ifc.ex_en;
            e_dok = rsp && !m_inst;
            chk("rnd_inst_addr_ok", 64'(ifc.inst_addr_ok), 64'(gi));
            chk("rnd_data_addr_ok", 64'(ifc.data_addr_ok), 64'(gd));
            chk("rnd_inst_data_ok", 64'(ifc.inst_data_ok), 64'(e_iok));
            chk("rnd_inst_rdata", 64'(ifc.inst_rdata), e_iok ? 64'(ifc.bus_rdata) : 64'h0);
            chk("rnd_data_data_ok", 64'(ifc.data_data_ok), 64'(e_dok));
            chk("rnd_data_rdata", 64'(ifc.data_rdata),
                (e_dok && !m_wr) ? 64'(ifc.bus_rdata) : 64'h0);
            chk("rnd_bus_req", 64'(ifc.bus_req), 64'(m_active && !m_acc));
            chk("rnd_busy", 64'(ifc.busy), 64'(m_active));
            chk("rnd_bus_fields", {25'(0), ifc.bus_wr, ifc.bus_size, ifc.bus_wstrb, ifc.bus_addr},
                {25'(0), m_wr, m_size, m_wstrb, m_addr});
            chk("rnd_bus_wdata", 64'(ifc.bus_wdata), 64'(m_wdata));
            @(posedge clk);
            if (!m_active) begin
                if (gd) begin
                    m_active = 1'b1; m_inst = 1'b0;
                    m_wr = ifc.data_wr; m_size = ifc.data_size; m_wstrb = ifc.data_wstrb;
                    m_addr = ifc.data_addr; m_wdata = ifc.data_wdata;
                    m_starve = ifc.inst_req ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
                end else if (gi) begin
                    m_active = 1'b1; m_inst = 1'b1;
                    m_wr = 1'b0; m_size = 2'd2; m_wstrb = '0;
                    m_addr = ifc.inst_addr; m_wdata = '0;
                    m_starve = 0;
                end else if (!ifc.inst_req) begin
                    m_starve = 0;
                end
            end else if (!m_acc) begin
                if (m_inst && ifc.ex_en) m_drop = 1'b1;
                if (ifc.bus_addr_ok) m_acc = 1'b1;
            end else if (rsp) begin
                m_active = 1'b0; m_acc = 1'b0; m_drop = 1'b0;
            end else if (m_inst && ifc.ex_en) begin
                m_drop = 1'b1;
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
